// File: rtl/mem_system_assoc.sv
// mem_system_assoc: write-back write-allocate 1/2-way cache over four_bank_mem; define VICTIM_LRU_EN for per-set LRU victims
module cache #(
  parameter int cache_id = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        createdump,
  input  logic        enable,
  input  logic        comp,
  input  logic        write,
  input  logic        valid_in,
  input  logic [4:0]  tag_in,
  input  logic [7:0]  index,
  input  logic [2:0]  offset,
  input  logic [15:0] data_in,
  output logic [4:0]  tag_out,
  output logic [15:0] data_out,
  output logic        hit,
  output logic        dirty,
  output logic        valid,
  output logic        err
);
  logic [4:0]   r_tag [256];
  logic [15:0]  r_data [256][4];
  logic [255:0] r_valid, r_dirty;
  logic         w_match, w_unused;
  assign w_unused = ^{createdump, cache_id};
  assign w_match  = r_valid[index] && r_tag[index] == tag_in;
  assign hit      = enable && comp && w_match;
  assign tag_out  = r_tag[index];
  assign data_out = r_data[index][offset[2:1]];
  assign valid    = r_valid[index];
  assign dirty    = r_dirty[index];
  assign err      = enable && offset[0];
  // compare-mode writes land only on a hit and dirty the line; raw writes reload tag/valid and leave it clean
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (enable && write && !offset[0] && (!comp || w_match)) begin
      r_data[index][offset[2:1]] <= data_in;
      r_dirty[index] <= comp;
      if (!comp) begin
        r_tag[index]   <= tag_in;
        r_valid[index] <= valid_in;
      end
    end
  end
endmodule

// four_bank_mem: word-interleaved banks, 4-cycle bank busy, read data 2 cycles after issue;
// unwritten words read as a fixed address-derived pattern, and reset forgets all writes
module four_bank_mem (
  input  logic        clk,
  input  logic        rst,
  input  logic        createdump,
  input  logic        wr,
  input  logic        rd,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        stall,
  output logic        err
);
  logic [15:0]      r_mem [32768];
  logic [32767:0]   r_wrt;
  logic [3:0][1:0]  r_busy;
  logic [15:0]      r_d1, w_init;
  logic             w_go, w_unused;
  assign w_unused = createdump;
  assign w_init   = ({1'b0, addr[15:1]} * 16'h9e37) ^ 16'h5a5a;
  assign stall    = (rd || wr) && r_busy[addr[2:1]] != 2'd0;
  assign err      = (rd || wr) && (addr[0] || (rd && wr));
  assign w_go     = (rd ^ wr) && !stall && !addr[0];
  // bank busy countdown, write port and two-stage read pipeline
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrt    <= '0;
      r_busy   <= '0;
      r_d1     <= '0;
      data_out <= '0;
    end else begin
      for (int b = 0; b < 4; b++) r_busy[b] <= r_busy[b] - 2'(r_busy[b] != 2'd0);
      if (w_go) r_busy[addr[2:1]] <= 2'd3;
      if (w_go && wr) begin
        r_mem[addr[15:1]] <= data_in;
        r_wrt[addr[15:1]] <= 1'b1;
      end
      r_d1     <= r_wrt[addr[15:1]] ? r_mem[addr[15:1]] : w_init;
      data_out <= r_d1;
    end
  end
endmodule

module mem_system_assoc #(
  parameter int memtype  = 0,
  parameter int NUM_WAYS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  input  logic        createdump,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        err
);
  typedef enum logic [3:0] {
    S_IDLE, S_WB0, S_WB1, S_WB2, S_WB3, S_RD0, S_RD1, S_RW2, S_RW3, S_RW4, S_RW5, S_FINAL
  } state_t;
  state_t          r_state, w_next;
  logic [1:0]      w_en, w_hit, w_valid, w_dirty, w_cerr, w_k;
  logic [1:0][4:0] w_tag;
  logic [1:0][15:0] w_dout;
  logic            w_comp, w_write, w_req, w_bad, w_hit_any, w_hway, w_vict, w_wb, w_pref;
  logic            w_is_wb, w_is_rd, w_fill, w_done, w_mstall, w_merr;
  logic [2:0]      w_coff;
  logic [4:0]      w_ctag;
  logic [7:0]      w_cidx;
  logic [15:0]     w_cdin, w_maddr, w_mdout;
  logic            r_way, r_wr, r_err;
  logic [15:0]     r_addr, r_data;
  logic [2:0]      r_p1, r_p2;

  for (genvar g = 0; g < 2; g++) begin : g_way
    if (g < NUM_WAYS) begin : g_c
      cache #(.cache_id(2 * memtype + g)) u_cache (
        .clk(clk), .rst(rst), .createdump(createdump), .enable(w_en[g]), .comp(w_comp),
        .write(w_write), .valid_in(1'b1), .tag_in(w_ctag), .index(w_cidx), .offset(w_coff),
        .data_in(w_cdin), .tag_out(w_tag[g]), .data_out(w_dout[g]), .hit(w_hit[g]),
        .dirty(w_dirty[g]), .valid(w_valid[g]), .err(w_cerr[g]));
    end else begin : g_z
      assign w_tag[g]   = '0;
      assign w_dout[g]  = '0;
      assign w_hit[g]   = 1'b0;
      assign w_dirty[g] = 1'b0;
      assign w_valid[g] = 1'b0;
      assign w_cerr[g]  = 1'b0;
    end
  end

  four_bank_mem u_mem (
    .clk(clk), .rst(rst), .createdump(createdump), .wr(w_is_wb), .rd(w_is_rd), .addr(w_maddr),
    .data_in(w_dout[r_way]), .data_out(w_mdout), .stall(w_mstall), .err(w_merr));

  assign w_req     = (Rd ^ Wr) && !Addr[0];
  assign w_bad     = (Rd && Wr) || ((Rd ^ Wr) && Addr[0]);
  assign w_hit_any = |w_hit;
  assign w_hway    = !w_hit[0];
  assign w_vict    = !w_valid[0] ? 1'b0 : NUM_WAYS == 1 ? 1'b0 : !w_valid[1] ? 1'b1 : w_pref;
  assign w_wb      = w_valid[w_vict] && w_dirty[w_vict];
  assign w_is_wb   = r_state >= S_WB0 && r_state <= S_WB3;
  assign w_is_rd   = r_state >= S_RD0 && r_state <= S_RW3;
  assign w_fill    = r_p2[2];
  assign w_k       = w_is_wb ? 2'(r_state - S_WB0) : 2'(r_state - S_RD0);
  assign w_done    = (r_state == S_IDLE && (w_bad || (w_req && w_hit_any))) || r_state == S_FINAL;

`ifdef VICTIM_LRU_EN
  logic [255:0] r_lru;
  // point each set's LRU bit away from the way just hit or filled
  always_ff @(posedge clk) begin
    if (rst) r_lru <= '0;
    else if (r_state == S_IDLE && w_req && w_hit_any) r_lru[Addr[10:3]] <= !w_hway;
    else if (r_state == S_FINAL) r_lru[r_addr[10:3]] <= !r_way;
  end
  assign w_pref = r_lru[Addr[10:3]];
`else
  logic r_vw;
  // global victim pointer flips on every accepted access, hits included
  always_ff @(posedge clk) r_vw <= rst ? 1'b0 : r_vw ^ (r_state == S_IDLE && w_req);
  assign w_pref = r_vw;
`endif

  // state register
  always_ff @(posedge clk) r_state <= rst ? S_IDLE : w_next;

  // miss path walks WB/RD states in order, holding whenever memory stalls
  always_comb
    w_next = r_state == S_IDLE ? ((w_req && !w_hit_any) ? (w_wb ? S_WB0 : S_RD0) : S_IDLE) :
             r_state == S_FINAL ? S_IDLE :
             w_mstall ? r_state : state_t'(r_state + 4'd1);

  // cache/memory drive and request outputs; fills follow returned read data, not the state
  always_comb begin
    w_comp   = r_state == S_IDLE || r_state == S_FINAL;
    w_cidx   = r_state == S_IDLE ? Addr[10:3] : r_addr[10:3];
    w_ctag   = r_state == S_IDLE ? Addr[15:11] : r_addr[15:11];
    w_write  = r_state == S_IDLE ? Wr : r_state == S_FINAL ? r_wr : w_fill;
    w_coff   = w_comp ? (r_state == S_IDLE ? Addr[2:0] : r_addr[2:0]) : {w_fill ? r_p2[1:0] : w_k, 1'b0};
    w_cdin   = r_state == S_IDLE ? DataIn : r_state == S_FINAL ? r_data : w_mdout;
    w_en     = r_state == S_IDLE ? {2{w_req}} :
               (w_fill || w_is_wb || r_state == S_FINAL) ? (r_way ? 2'b10 : 2'b01) : 2'b00;
    w_maddr  = w_is_wb ? {w_tag[r_way], r_addr[10:3], w_k, 1'b0} : {r_addr[15:3], w_k, 1'b0};
    Done     = w_done;
    Stall    = r_state != S_IDLE;
    CacheHit = r_state == S_IDLE && w_req && w_hit_any;
    err      = r_state == S_IDLE ? w_bad || (w_req && w_hit_any && |w_cerr) :
               r_state == S_FINAL && (r_err || |w_cerr || w_merr);
    DataOut  = w_done ? w_dout[r_state == S_IDLE ? w_hway : r_way] : 16'h0;
  end

  // latch the missing request and victim, track in-flight reads, accumulate errors
  always_ff @(posedge clk) begin
    if (rst) begin
      r_p1   <= '0;
      r_p2   <= '0;
      r_err  <= 1'b0;
      r_way  <= 1'b0;
      r_wr   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else begin
      r_p1  <= {w_is_rd && !w_mstall, w_k};
      r_p2  <= r_p1;
      r_err <= r_state == S_IDLE ? 1'b0 : r_err || |w_cerr || w_merr;
      if (r_state == S_IDLE && w_req && !w_hit_any) begin
        r_way  <= w_vict;
        r_addr <= Addr;
        r_data <= DataIn;
        r_wr   <= Wr;
      end
    end
  end
endmodule

// File: tb/tb_mem_system_assoc.sv
// tb_mem_system_assoc: directed and random requests checked against a line-level cache/memory model
module tb_mem_system_assoc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  rd_i = '0, wr_i = '0, done_w, stall_w, hit_w, err_w;
  logic [15:0] addr_i [2];
  logic [15:0] din_i [2];
  logic [15:0] dout_w [2];
  int          tests = 0, fails = 0;
  logic [4:0]  mt [2][2][256];
  bit          mv [2][2][256];
  bit          md [2][2][256];
  logic [15:0] mdat [2][2][256][4];
  bit          vw [2];
  logic [15:0] mm [int];

  always #5 clk = ~clk;

  mem_system_assoc u_dut (
    .clk(clk), .rst(rst), .Addr(addr_i[0]), .DataIn(din_i[0]), .Rd(rd_i[0]), .Wr(wr_i[0]),
    .createdump(1'b0), .DataOut(dout_w[0]), .Done(done_w[0]), .Stall(stall_w[0]),
    .CacheHit(hit_w[0]), .err(err_w[0]));

  mem_system_assoc #(.memtype(1), .NUM_WAYS(1)) u_dm (
    .clk(clk), .rst(rst), .Addr(addr_i[1]), .DataIn(din_i[1]), .Rd(rd_i[1]), .Wr(wr_i[1]),
    .createdump(1'b0), .DataOut(dout_w[1]), .Done(done_w[1]), .Stall(stall_w[1]),
    .CacheHit(hit_w[1]), .err(err_w[1]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem_rd(input int d, input logic [14:0] wa);
    logic [15:0] w16 = {1'b0, wa};
    return mm.exists(d * 32768 + int'(wa)) ? mm[d * 32768 + int'(wa)] : (w16 * 16'h9e37) ^ 16'h5a5a;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int w = 0; w < 2; w++)
        for (int i = 0; i < 256; i++) begin
          mv[d][w][i] = 1'b0;
          md[d][w][i] = 1'b0;
        end
    vw[0] = 1'b0;
    vw[1] = 1'b0;
    mm.delete();
  endtask

  task automatic model(input int d, input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] din,
                       output int lat, output bit eh, output bit ee, output logic [15:0] ed);
    int nw = d == 0 ? 2 : 1;
    int hw = -1;
    int v = -1;
    logic [7:0] idx = a[10:3];
    logic [4:0] tg = a[15:11];
    logic [1:0] k = a[2:1];
    bit pref;
    lat = 0; eh = 1'b0; ee = 1'b0; ed = 16'h0;
    if ((rd && wr) || a[0]) begin
      ee = 1'b1;
      return;
    end
    for (int w = 0; w < nw; w++) if (mv[d][w][idx] && mt[d][w][idx] == tg) hw = w;
    pref = vw[d];
    vw[d] = !vw[d];
    if (hw >= 0) begin
      eh = 1'b1;
      ed = mdat[d][hw][idx][k];
      if (wr) begin
        mdat[d][hw][idx][k] = din;
        md[d][hw][idx] = 1'b1;
      end
      return;
    end
    for (int w = 0; w < nw; w++) if (v < 0 && !mv[d][w][idx]) v = w;
    if (v < 0) v = nw == 2 ? int'(pref) : 0;
    lat = 7;
    if (mv[d][v][idx] && md[d][v][idx]) begin
      lat = 11;
      for (int j = 0; j < 4; j++) mm[d * 32768 + int'({mt[d][v][idx], idx, 2'(j)})] = mdat[d][v][idx][j];
    end
    for (int j = 0; j < 4; j++) mdat[d][v][idx][j] = mem_rd(d, {tg, idx, 2'(j)});
    mt[d][v][idx] = tg;
    mv[d][v][idx] = 1'b1;
    md[d][v][idx] = 1'b0;
    ed = mdat[d][v][idx][k];
    if (wr) begin
      mdat[d][v][idx][k] = din;
      md[d][v][idx] = 1'b1;
    end
  endtask

  task automatic drive(input int d, input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] din);
    rd_i[d] = rd;
    wr_i[d] = wr;
    addr_i[d] = a;
    din_i[d] = din;
  endtask

  task automatic do_req(input int d, input bit rd, input bit wr, input logic [15:0] a, input logic [15:0] din);
    int lat = 0;
    int elat;
    bit eh, ee, stall_ok = 1'b1;
    logic [15:0] ed;
    model(d, rd, wr, a, din, elat, eh, ee, ed);
    @(posedge clk); #1;
    drive(d, rd, wr, a, din);
    @(negedge clk);
    check($sformatf("d%0d a=%h stall0", d, a), 32'(stall_w[d]), 32'd0);
    while (!done_w[d] && lat < 40) begin
      @(posedge clk); #1;
      drive(d, 1'b0, 1'b0, 16'h0, 16'h0);
      lat++;
      @(negedge clk);
      if (!stall_w[d]) stall_ok = 1'b0;
    end
    check($sformatf("d%0d a=%h latency", d, a), 32'(lat), 32'(elat));
    check($sformatf("d%0d a=%h hit", d, a), 32'(hit_w[d]), 32'(eh));
    check($sformatf("d%0d a=%h err", d, a), 32'(err_w[d]), 32'(ee));
    if (rd && !wr && !ee) check($sformatf("d%0d a=%h dout", d, a), 32'(dout_w[d]), 32'(ed));
    if (elat > 0) check($sformatf("d%0d a=%h stall_hold", d, a), 32'(stall_ok), 32'd1);
    if (lat == 0) begin
      @(posedge clk); #1;
      drive(d, 1'b0, 1'b0, 16'h0, 16'h0);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      check($sformatf("d%0d reset outs", d), 32'({done_w[d], stall_w[d], hit_w[d], err_w[d]}), 32'd0);
  endtask

  initial begin
    logic [15:0] a;
    int r;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    do_reset();
    do_req(0, 1, 0, 16'h0010, 16'h0);
    do_req(0, 1, 0, 16'h0010, 16'h0);
    do_req(0, 0, 1, 16'h0020, 16'hbeef);
    do_req(0, 1, 0, 16'h0020, 16'h0);
    do_req(0, 0, 1, 16'h0820, 16'h1111);
    do_req(0, 0, 1, 16'h1020, 16'h2222);
    do_req(0, 1, 0, 16'h1820, 16'h0);
    do_req(0, 1, 0, 16'h1020, 16'h0);
    do_req(0, 1, 0, 16'h0820, 16'h0);
    do_req(0, 1, 1, 16'h0020, 16'h0);
    do_req(0, 1, 0, 16'h0003, 16'h0);
    do_req(0, 0, 1, 16'h0821, 16'h5555);
    do_req(0, 1, 0, 16'h0820, 16'h0);
    for (int i = 0; i < 4; i++) do_req(1, 1, 0, i[0] ? 16'h0808 : 16'h0008, 16'h0);
    for (int i = 0; i < 280; i++) begin
      int d = i % 7 < 5 ? 0 : 1;
      r = $urandom_range(0, 9);
      a = {5'($urandom_range(0, 5)), 8'($urandom_range(0, 2) == 0 ? 200 : $urandom_range(4, 5)),
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 19) == 0)};
      do_req(d, r <= 5, r == 0 || r >= 6, a, 16'($urandom));
    end
    do_reset();
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 16'h3a40, 16'h0);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    check("midmiss reset stall/done", 32'({stall_w[0], done_w[0]}), 32'd0);
    do_req(0, 1, 0, 16'h3a40, 16'h0);
    do_req(0, 1, 0, 16'h3a40, 16'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_system_assoc.md
Name: mem_system_assoc

Overview:
Parametrised successor to the direct-mapped memory system: a write-back, write-allocate cache of 1 or 2 ways in front of four_bank_mem.
- Contains the cache instances (cache #(...)), one four_bank_mem, and an integrated controller FSM. The controller supports set-associative victim selection and write-back of dirty lines.
- Addr split: tag [15:11], index [10:3], offset [2:0]; line = 4 words; offset[0] must be 0.
- Sits between the pipeline fetch/memory stage and main memory. Instruction instance uses memtype=0; data instance uses memtype=1.

Parameters:
memtype, 0, 0 = instruction memory, 1 = data memory; cache IDs are (2*memtype + way).
NUM_WAYS, 2, 1 or 2 cache ways; 1 gives direct-mapped behaviour with no victim logic.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
Addr  input  16  byte address of request
DataIn  input  16  write data
Rd  input  1  read request, sampled when Stall=0
Wr  input  1  write request, sampled when Stall=0
createdump  input  1  forwarded to all cache and memory instances
DataOut  output  16  read data, valid in the cycle Done=1
Done  output  1  one-cycle pulse: request complete
Stall  output  1  controller busy, new requests ignored
CacheHit  output  1  with Done: request hit in a valid way
err  output  1  error flag, valid with Done

Behaviour:
- Reset (clk edge with rst=1): FSM -> IDLE; victim state -> 0. Done, Stall, CacheHit, err = 0. Any outstanding memory ops are abandoned even mid-miss; cache contents are owned by the cache instances.
- IDLE/COMPARE (combined): on Rd^Wr, all ways are accessed in compare mode at the same time.
  - Hit = any way with hit&valid. On a hit, Done=1 and CacheHit=1 in that same cycle; DataOut comes from the hitting way.
  - A write hit writes only the hitting way and sets dirty. Zero-cycle hit latency; Stall=0.
- Rd&Wr both 1: no access; Done=1, err=1 in the same cycle.
- Miss, victim choice:
  - First invalid way, way0 preferred.
  - If all ways are valid, victim = victimway (NUM_WAYS=2) or way0 (NUM_WAYS=1).
  - Victim way, Addr, DataIn and Rd/Wr are latched. Stall=1 from the next cycle until Done.
- WB0..WB3 (only if victim valid&dirty): each cycle, read victim word k from the cache (comp=0) and write it to memory at {victim tag, index, k, 0}.
- RD0..RD3: issue memory read of word k of {tag, index}.
- RW2..RW5: memory data returns 2 cycles after each read is issued. Each returned word is written into the victim way (comp=0, write=1, valid_in=1), which clears dirty.
- Memory handshake: if m_stall=1, the FSM holds its state and reissues the same word next cycle.
- FINAL: replay the latched request in compare mode on the victim way; the write sets dirty. Done=1, CacheHit=0, DataOut = word read. Next state IDLE.
- Latency from request cycle (no m_stall):
  - Clean miss: Done at cycle +7.
  - Dirty miss: Done at cycle +11.
- victimway (global flop): toggles on every accepted Rd or Wr, including hits. It is sampled before the toggle.
- err: OR of all cache err, m_err and the illegal-request error, latched over a transaction. Reported with Done, then cleared. An odd address (Addr[0]=1) sets err and completes with no access.
- Rd/Wr while Stall=1 are ignored. Outputs are held only in the Done cycle.

Optional Feature:
VICTIM_LRU_EN
- Defined: the global victimway flop is replaced by a 256x1 per-set LRU array.
  - On a hit or fill, the set's bit is updated to point to the other way.
  - Victim = LRU bit when both ways are valid.
  - Array clears to 0 on reset.
- Undefined: global toggle policy as above. Has no effect when NUM_WAYS=1.

Test Plan:
- Reset, Rd Addr=0x0010 -> miss; Done at cycle +7, CacheHit=0, DataOut = mem[0x0010]. Repeat the read -> Done the same cycle with CacheHit=1.
- Wr 0x0020 DataIn=0xBEEF, then Rd 0x0020 -> second access hits, DataOut=0xBEEF, CacheHit=1.
- NUM_WAYS=2, fill index 4 with tags 0x01 and 0x02 (dirty), then read tag 0x03 -> evicts the victimway way. If dirty, Done at +11; memory receives 4 writebacks at {0x02,4,k}. Read tag 0x02 again -> value returned intact.
- NUM_WAYS=1, alternate reads 0x0008 / 0x0808 (same index) -> every access misses, Done at +7 each time.
- Rd=Wr=1 -> Done=1, err=1, same cycle, no state change. Addr=0x0003 -> err=1.
- Assert rst during RD2 of a miss -> next cycle Stall=0, Done=0; a new Rd completes normally.
